// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serial-status bundle for the buffered UART transmitter.
// The master side writes bytes; the slave side (the transmitter) reports line and FIFO state.
`timescale 1ns/1ps
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     i_Tx_DV;
  logic [7:0]               i_Tx_Byte;
  logic                     o_Tx_Ready;
  logic                     o_Tx_Serial;
  logic                     o_Tx_Active;
  logic                     o_Tx_Done;
  logic                     o_Overflow;
  logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a circular FIFO and are
// serialised LSB first, with back-to-back frames sent without an idle gap.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 87,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic         i_Clock,
  input  logic         i_Rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int              DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int              CW       = FIFO_DEPTH_LOG2 + 1;
  localparam logic [15:0]     BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   FULL     = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;

  logic ready, wr_en, pop, bit_end, not_empty;

  assign ready     = (count_q != FULL);
  assign wr_en     = bus.i_Tx_DV & ready;
  assign not_empty = (count_q != '0);
  assign bit_end   = (cnt_q == BIT_LAST);

  assign bus.o_Tx_Ready   = ready;
  assign bus.o_Tx_Serial  = serial_q;
  assign bus.o_Tx_Active  = (state_q != IDLE);
  assign bus.o_Tx_Done    = (state_q == STOP) && bit_end;
  assign bus.o_Overflow   = bus.i_Tx_DV & ~ready;
  assign bus.o_Fifo_Count = count_q;

  // Readiness is judged on the registered count, so a pop in the same cycle never frees room for a write.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.i_Tx_Byte;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (not_empty) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d    = '0;
          serial_d = shift_q[0];
          idx_d    = '0;
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = shift_q[1];
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (not_empty) begin
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            serial_d = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: exact line timing, bursts, overflow,
// full/pop collision, reset mid-frame and a 256-byte stream through a serial decoder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int L   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(L)) bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         act_cnt = 0;
  int         done_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.o_Tx_Done === 1'b1)   done_q.push_back(cyc);
    if (bus.o_Overflow === 1'b1)  ovf_cnt++;
    if (bus.o_Tx_Active === 1'b1) act_cnt++;
  end

  // Independent receiver: finds the start bit, samples each bit in its second cycle.
  initial forever begin
    @(negedge clk);
    if (bus.o_Tx_Serial === 1'b0) begin
      repeat (CPB + 1) @(negedge clk);
      rx_b[0] = bus.o_Tx_Serial;
      for (int i = 1; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        rx_b[i] = bus.o_Tx_Serial;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop_bit", bus.o_Tx_Serial, 1);
      rx_q.push_back(rx_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic put(input logic [7:0] b);
    bus.i_Tx_DV   = 1'b1;
    bus.i_Tx_Byte = b;
    @(posedge clk); #1;
    bus.i_Tx_DV   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      @(posedge clk); #1;
      if (!bus.o_Tx_Active && bus.o_Fifo_Count == 0) ok = 1'b1;
    end
    repeat (2) @(posedge clk); #1;
    check({tag, "_idle_timeout"}, ok, 1);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "_rx_byte"}, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic clear();
    rx_q.delete(); done_q.delete(); exp_q.delete();
    ovf_cnt = 0; act_cnt = 0;
  endtask

  initial begin
    logic [9:0] frame;
    logic       found;
    bus.i_Tx_DV   = 1'b0;
    bus.i_Tx_Byte = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_serial", bus.o_Tx_Serial, 1);
    check("rst_active", bus.o_Tx_Active, 0);
    check("rst_done",   bus.o_Tx_Done, 0);
    check("rst_ovf",    bus.o_Overflow, 0);
    check("rst_count",  bus.o_Fifo_Count, 0);
    check("rst_ready",  bus.o_Tx_Ready, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: single byte, exact cycle timing of every line sample
    clear();
    put(8'hA5);
    check("t1_count_after_write", bus.o_Fifo_Count, 1);
    check("t1_line_before_pop", bus.o_Tx_Serial, 1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10 * CPB; j++) begin
      @(posedge clk); #1;
      check("t1_line", bus.o_Tx_Serial, frame[j / CPB]);
      if (j == 0)  check("t1_count_after_pop", bus.o_Fifo_Count, 0);
      if (j == 0)  check("t1_active_first", bus.o_Tx_Active, 1);
      if (j == 38) check("t1_done_early", bus.o_Tx_Done, 0);
      if (j == 39) check("t1_done_last", bus.o_Tx_Done, 1);
      if (j == 39) check("t1_active_last", bus.o_Tx_Active, 1);
    end
    @(posedge clk); #1;
    check("t1_active_after", bus.o_Tx_Active, 0);
    check("t1_done_after", bus.o_Tx_Done, 0);
    exp_q = '{8'hA5};
    check_rx("t1");

    // 2: burst of three contiguous frames
    clear();
    put(8'h00); put(8'hFF); put(8'h3C);
    wait_idle("t2", 400);
    check("t2_done_pulses", done_q.size(), 3);
    check("t2_done_gap1", done_q[1] - done_q[0], 40);
    check("t2_done_gap2", done_q[2] - done_q[1], 40);
    check("t2_active_cycles", act_cnt, 120);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    check_rx("t2");

    // 3: six consecutive writes, the sixth hits a full FIFO
    clear();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 6; i++) begin
      bus.i_Tx_DV   = 1'b1;
      bus.i_Tx_Byte = 8'h11 * 8'(i + 1);
      if (i == 5) begin
        #1;
        check("t3_count_full", bus.o_Fifo_Count, 4);
        check("t3_ready_full", bus.o_Tx_Ready, 0);
        check("t3_ovf_flag", bus.o_Overflow, 1);
      end
      @(posedge clk); #1;
    end
    bus.i_Tx_DV = 1'b0;
    check("t3_count_after_drop", bus.o_Fifo_Count, 4);
    wait_idle("t3", 400);
    check("t3_ovf_pulses", ovf_cnt, 1);
    check("t3_done_pulses", done_q.size(), 5);
    check_rx("t3");

    // 4: write attempt on the STOP-exit pop edge while full
    clear();
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 5; i++) put(exp_q[i]);
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.o_Tx_Done) found = 1'b1;
    end
    check("t4_done_seen", found, 1);
    bus.i_Tx_DV   = 1'b1;
    bus.i_Tx_Byte = 8'hEE;
    #1;
    check("t4_ovf_flag", bus.o_Overflow, 1);
    check("t4_count_before", bus.o_Fifo_Count, 4);
    @(posedge clk); #1;
    bus.i_Tx_DV = 1'b0;
    check("t4_count_after", bus.o_Fifo_Count, 3);
    check("t4_next_start", bus.o_Tx_Serial, 0);
    wait_idle("t4", 400);
    check("t4_ovf_pulses", ovf_cnt, 1);
    check_rx("t4");

    // 5: reset during data bit 3 with bytes still queued
    clear();
    put(8'h5A); put(8'hC3); put(8'h96);
    repeat (16) @(posedge clk); #2;
    check("t5_active_pre", bus.o_Tx_Active, 1);
    check("t5_count_pre", bus.o_Fifo_Count, 2);
    rst_n = 1'b0;
    #1;
    check("t5_serial_rst", bus.o_Tx_Serial, 1);
    check("t5_count_rst", bus.o_Fifo_Count, 0);
    check("t5_active_rst", bus.o_Tx_Active, 0);
    repeat (60) @(posedge clk);
    rx_q.delete(); act_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("t5_no_residual_rx", rx_q.size(), 0);
    check("t5_no_residual_active", act_cnt, 0);
    check("t5_line_idle", bus.o_Tx_Serial, 1);

    // 6: stream 0x00..0xFF, writing whenever there is room
    clear();
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      for (int t = 0; t < 200 && !bus.o_Tx_Ready; t++) begin
        @(posedge clk); #1;
      end
      put(8'(b));
    end
    wait_idle("t6", 400);
    check("t6_done_pulses", done_q.size(), 256);
    check("t6_ovf_pulses", ovf_cnt, 0);
    check_rx("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
